// File: rtl/key_note_sequencer.sv
// -----------------------------------------------------------------------------
// key_note_sequencer
//
// Sits between the keypad scanner and pwm_audio. It turns the one-hot key
// vector into a 10-bit tone divisor N and can record the note/rest sequence
// (with durations measured in ticks) and replay it with the same timing.
//
//   IDLE : N follows the decoded key (registered, 1-cycle latency).
//   REC  : N follows the keys; {code, dur} segments are written to a buffer.
//   PLAY : buffer entries are replayed onto N; the keypad is ignored.
//
// Parameters
//   TICK_DIV : clk cycles per duration tick (must be >= 2)
//   DEPTH    : number of buffer entries (must be >= 2)
//   DUR_W    : width of the per-entry duration field in ticks
//
// Ports
//   clk       : system clock
//   rst       : synchronous active-high reset
//   keys      : one-hot key vector from the keypad scanner
//   rec       : single-cycle pulse, start/stop recording
//   play      : single-cycle pulse, start/abort playback
//   N         : tone divisor to pwm_audio, 0 = silence
//   recording : high while recording
//   playing   : high while playing back
//   count     : number of valid entries in the buffer
//
// Build option
//   LOOP_EN : when defined, playback wraps from the last entry back to entry 0
//             and only a play pulse or rst leaves playback. When undefined,
//             playback is a single pass ending with N=0.
// -----------------------------------------------------------------------------
module key_note_sequencer #(
    parameter int TICK_DIV = 1000000,
    parameter int DEPTH    = 32,
    parameter int DUR_W    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [15:0]              keys,
    input  logic                     rec,
    input  logic                     play,
    output logic [9:0]               N,
    output logic                     recording,
    output logic                     playing,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int EW = 3 + DUR_W;
    localparam logic [DUR_W-1:0] DUR_MAX = '1;

    // S_LOAD is the first playback cycle: the registered RAM output for
    // entry 0 becomes valid here and is transferred to N on the next edge.
    typedef enum logic [1:0] {
        S_IDLE,
        S_REC,
        S_LOAD,
        S_PLAY
    } state_t;

    // ------------------------------------------------------------------------
    // Key decode and divisor lookup
    // ------------------------------------------------------------------------
    function automatic logic [2:0] key_code(input logic [15:0] k);
        case (k)
            16'h0001: return 3'd1;
            16'h0400: return 3'd2;
            16'h0800: return 3'd3;
            16'h1000: return 3'd4;
            16'h2000: return 3'd5;
            16'h4000: return 3'd6;
            16'h8000: return 3'd7;
            default:  return 3'd0;
        endcase
    endfunction

    function automatic logic [9:0] code_div(input logic [2:0] c);
        case (c)
            3'd1:    return 10'd498;
            3'd2:    return 10'd444;
            3'd3:    return 10'd395;
            3'd4:    return 10'd747;
            3'd5:    return 10'd665;
            3'd6:    return 10'd593;
            3'd7:    return 10'd559;
            default: return 10'd0;
        endcase
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t              state_reg;
    logic [9:0]          n_reg;
    logic                recording_reg;
    logic                playing_reg;
    logic [CW-1:0]       count_reg;
    logic [2:0]          seg_code_reg;
    logic [DUR_W-1:0]    seg_dur_reg;
    logic [AW-1:0]       rd_ptr_reg;
    logic [DUR_W-1:0]    remain_reg;
    logic [TW-1:0]       tick_cnt_reg;
    logic [EW-1:0]       rd_data_reg;

    logic [EW-1:0]       mem [DEPTH];

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [2:0]          cur_code;
    logic                tick_en;
    logic                tick_restart;
    logic [DUR_W-1:0]    dur_next;
    logic                seg_end;
    logic                wr_en;
    logic [EW-1:0]       wr_data;
    logic [AW-1:0]       wr_addr;
    logic [CW-1:0]       count_next;
    logic                last_entry;
    logic [AW-1:0]       rd_ptr_next;
    logic [AW-1:0]       rd_addr;
    logic [2:0]          rd_code;
    logic [DUR_W-1:0]    rd_dur;

    always_comb begin
        cur_code = key_code(keys);
        tick_en  = (tick_cnt_reg == TW'(TICK_DIV - 1));

        // The counter restarts when REC is entered and on the playback load
        // cycle, so the first entry's first tick is a full period after N
        // takes the entry's divisor.
        tick_restart = ((state_reg == S_IDLE) && rec) ||
                       ((state_reg == S_LOAD) && !play);

        // A tick on the same edge as a segment boundary still belongs to the
        // segment that is ending: the key was held for that whole period.
        dur_next = seg_dur_reg + DUR_W'(tick_en);
        seg_end  = (cur_code != seg_code_reg) || (dur_next == DUR_MAX);

        // Zero-length segments (key changed before any tick) are dropped.
        wr_en    = (state_reg == S_REC) && (rec || seg_end) && (dur_next != '0);
        wr_data  = {seg_code_reg, dur_next};
        wr_addr  = count_reg[AW-1:0];
        count_next = count_reg + CW'(1);

        // During playback the RAM is always reading the entry after the one
        // being sounded, so an advance can update N on the same edge.
        last_entry  = ({1'b0, rd_ptr_reg} == (count_reg - CW'(1)));
        rd_ptr_next = last_entry ? '0 : (rd_ptr_reg + AW'(1));
        rd_addr     = (state_reg == S_IDLE) ? '0 : rd_ptr_next;

        rd_code = rd_data_reg[EW-1:DUR_W];
        rd_dur  = rd_data_reg[DUR_W-1:0];
    end

    // ------------------------------------------------------------------------
    // Sequence buffer: synchronous-read RAM, no reset on contents
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_reg <= mem[rd_addr];
    end

    // ------------------------------------------------------------------------
    // Duration tick generator
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || tick_restart) begin
            tick_cnt_reg <= '0;
        end else if (tick_en) begin
            tick_cnt_reg <= '0;
        end else begin
            tick_cnt_reg <= tick_cnt_reg + TW'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            n_reg         <= '0;
            recording_reg <= 1'b0;
            playing_reg   <= 1'b0;
            count_reg     <= '0;
            seg_code_reg  <= '0;
            seg_dur_reg   <= '0;
            rd_ptr_reg    <= '0;
            remain_reg    <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    n_reg <= code_div(cur_code);
                    // rec is tested first so it wins over a coincident play.
                    if (rec) begin
                        state_reg     <= S_REC;
                        recording_reg <= 1'b1;
                        count_reg     <= '0;
                        seg_code_reg  <= cur_code;
                        seg_dur_reg   <= '0;
                    end else if (play && (count_reg != '0)) begin
                        state_reg   <= S_LOAD;
                        playing_reg <= 1'b1;
                        n_reg       <= '0;
                        rd_ptr_reg  <= '0;
                    end
                end

                S_REC: begin
                    n_reg <= code_div(cur_code);
                    if (rec) begin
                        // Stop: flush the open segment (if non-empty).
                        if (wr_en) begin
                            count_reg <= count_next;
                        end
                        state_reg     <= S_IDLE;
                        recording_reg <= 1'b0;
                    end else if (seg_end) begin
                        // On saturation cur_code equals the old code, so the
                        // new segment continues the same note.
                        seg_code_reg <= cur_code;
                        seg_dur_reg  <= '0;
                        if (wr_en) begin
                            count_reg <= count_next;
                            if (count_next == CW'(DEPTH)) begin
                                state_reg     <= S_IDLE;
                                recording_reg <= 1'b0;
                            end
                        end
                    end else begin
                        seg_dur_reg <= dur_next;
                    end
                end

                S_LOAD: begin
                    if (play) begin
                        state_reg   <= S_IDLE;
                        playing_reg <= 1'b0;
                        n_reg       <= '0;
                    end else begin
                        state_reg  <= S_PLAY;
                        n_reg      <= code_div(rd_code);
                        remain_reg <= rd_dur;
                    end
                end

                S_PLAY: begin
                    if (play) begin
                        state_reg   <= S_IDLE;
                        playing_reg <= 1'b0;
                        n_reg       <= '0;
                    end else if (tick_en) begin
                        if (remain_reg == DUR_W'(1)) begin
`ifdef LOOP_EN
                            // rd_ptr_next already wraps to 0 after the last
                            // entry, and the RAM has prefetched entry 0.
                            rd_ptr_reg <= rd_ptr_next;
                            n_reg      <= code_div(rd_code);
                            remain_reg <= rd_dur;
`else
                            if (last_entry) begin
                                state_reg   <= S_IDLE;
                                playing_reg <= 1'b0;
                                n_reg       <= '0;
                            end else begin
                                rd_ptr_reg <= rd_ptr_next;
                                n_reg      <= code_div(rd_code);
                                remain_reg <= rd_dur;
                            end
`endif
                        end else begin
                            remain_reg <= remain_reg - DUR_W'(1);
                        end
                    end
                end

                default: begin
                    state_reg     <= S_IDLE;
                    recording_reg <= 1'b0;
                    playing_reg   <= 1'b0;
                    n_reg         <= '0;
                end
            endcase
        end
    end

    assign N         = n_reg;
    assign recording = recording_reg;
    assign playing   = playing_reg;
    assign count     = count_reg;

endmodule
